// File: rtl/counter_pkg.sv
// Shared types and constants for the counter access path.
package counter_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   localparam logic       OWN_WB   = 1'b0;
   localparam logic       OWN_LA   = 1'b1;
   localparam logic [3:0] LA_WSTRB = 4'hF;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer remembers the last winner (1 = LA).
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_q;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = last_q ? 2'b01 : 2'b10;
      end
   end

   // Resetting to LA hands the first tie to WB.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else if (en && (|req)) begin
         last_q <= gnt[1];
      end
   end

endmodule

// File: rtl/counter_access_arbiter.sv
// Serializes WB and LA requests onto the counter's valid/ready port with a bounded ready wait.
module counter_access_arbiter
   import counter_pkg::*;
#(
   parameter int unsigned BITS    = 32,
   parameter int unsigned TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            wb_valid,
   input  logic            wb_we,
   input  logic [3:0]      wb_sel,
   input  logic [BITS-1:0] wb_wdata,
   output logic            wb_ack,
   output logic            wb_err,
   output logic [BITS-1:0] wb_rdata,
   input  logic            la_req,
   input  logic [BITS-1:0] la_wdata,
   output logic            la_ack,
   output logic            ctr_valid,
   output logic [3:0]      ctr_wstrb,
   output logic [BITS-1:0] ctr_wdata,
   input  logic            ctr_ready,
   input  logic [BITS-1:0] ctr_rdata,
   output logic [1:0]      grant,
   output logic            busy
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   state_t          state_q, state_d;
   logic            owner_q, owner_d;
   logic [3:0]      wstrb_q, wstrb_d;
   logic [BITS-1:0] wdata_q, wdata_d;
   logic [BITS-1:0] rdata_q, rdata_d;
   logic            err_q, err_d;
   logic [CW-1:0]   wait_q, wait_d;
   logic [CW-1:0]   wait_inc;
   logic [1:0]      req;
   logic [1:0]      gnt;
   logic            arb_en;

   assign req      = {la_req, wb_valid};
   assign arb_en   = (state_q == IDLE);
   assign wait_inc = wait_q + CW'(1);

   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (arb_en),
      .req     (req),
      .gnt     (gnt)
   );

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      wstrb_d = wstrb_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wait_d  = wait_q;
      unique case (state_q)
         IDLE: begin
            wait_d = '0;
            if (|req) begin
               state_d = ISSUE;
               if (gnt[1]) begin
                  owner_d = OWN_LA;
                  wstrb_d = LA_WSTRB;
                  wdata_d = la_wdata;
               end else begin
                  owner_d = OWN_WB;
                  wstrb_d = wb_sel & {4{wb_we}};
                  wdata_d = wb_wdata;
               end
            end
         end
         ISSUE: begin
            wait_d = wait_inc;
            // Ready takes priority over a timeout landing in the same cycle.
            if (ctr_ready) begin
               rdata_d = ctr_rdata;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (wait_inc == CW'(TIMEOUT)) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         owner_q <= OWN_WB;
         wstrb_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wstrb_q <= wstrb_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      ctr_valid = (state_q == ISSUE);
      ctr_wstrb = wstrb_q;
      ctr_wdata = wdata_q;
      wb_ack    = (state_q == RESP) && (owner_q == OWN_WB);
      la_ack    = (state_q == RESP) && (owner_q == OWN_LA);
      wb_err    = wb_ack && err_q;
      wb_rdata  = wb_ack ? rdata_q : '0;
      grant     = '0;
      if (busy) begin
         grant = (owner_q == OWN_LA) ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: tb/tb_counter_access_arbiter.sv
// Self-checking bench: directed scenarios then random traffic against a transaction-level model.
module tb_counter_access_arbiter;

   localparam int unsigned BITS    = 32;
   localparam int unsigned TIMEOUT = 15;

   logic            clk = 1'b0;
   logic            reset_n = 1'b1;
   logic            wb_valid = 1'b0;
   logic            wb_we = 1'b0;
   logic [3:0]      wb_sel = '0;
   logic [BITS-1:0] wb_wdata = '0;
   logic            wb_ack, wb_err;
   logic [BITS-1:0] wb_rdata;
   logic            la_req = 1'b0;
   logic [BITS-1:0] la_wdata = '0;
   logic            la_ack, ctr_valid;
   logic [3:0]      ctr_wstrb;
   logic [BITS-1:0] ctr_wdata;
   logic            ctr_ready = 1'b0;
   logic [BITS-1:0] ctr_rdata = '0;
   logic [1:0]      grant;
   logic            busy;

   int total = 0;
   int bad   = 0;
   bit m_last = 1'b1;  // model round-robin pointer, 1 = LA served last

   counter_access_arbiter #(.BITS(BITS), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wb_valid  (wb_valid),
      .wb_we     (wb_we),
      .wb_sel    (wb_sel),
      .wb_wdata  (wb_wdata),
      .wb_ack    (wb_ack),
      .wb_err    (wb_err),
      .wb_rdata  (wb_rdata),
      .la_req    (la_req),
      .la_wdata  (la_wdata),
      .la_ack    (la_ack),
      .ctr_valid (ctr_valid),
      .ctr_wstrb (ctr_wstrb),
      .ctr_wdata (ctr_wdata),
      .ctr_ready (ctr_ready),
      .ctr_rdata (ctr_rdata),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=no_finish required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_wb_ack"}, wb_ack, 0);
      chk({tag, "_wb_err"}, wb_err, 0);
      chk({tag, "_la_ack"}, la_ack, 0);
      chk({tag, "_ctr_valid"}, ctr_valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_wb_rdata"}, wb_rdata, 0);
      chk({tag, "_ctr_wdata"}, ctr_wdata, 0);
      chk({tag, "_ctr_wstrb"}, ctr_wstrb, 0);
      chk({tag, "_grant"}, grant, 0);
   endtask

   task automatic raise_wb(input bit we, input logic [3:0] sel, input logic [31:0] d);
      wb_valid = 1'b1;
      wb_we    = we;
      wb_sel   = sel;
      wb_wdata = d;
   endtask

   task automatic raise_la(input logic [31:0] d);
      la_req   = 1'b1;
      la_wdata = d;
   endtask

   // Called #1 after a posedge with the DUT idle and requests on the inputs.
   // ready_at: ISSUE cycle (1-based) on which ready is given; 0 = never.
   task automatic serve(input int ready_at, input logic [31:0] rd);
      bit          own;
      bit          ok_rdy;
      logic [3:0]  exp_s;
      logic [31:0] exp_d;
      logic [1:0]  exp_g;
      int          n;
      int          exp_n;
      own    = (wb_valid && la_req) ? ~m_last : la_req;
      m_last = own;
      exp_s  = own ? 4'hF : (wb_sel & {4{wb_we}});
      exp_d  = own ? la_wdata : wb_wdata;
      exp_g  = own ? 2'b10 : 2'b01;
      ok_rdy = (ready_at >= 1) && (ready_at <= int'(TIMEOUT));
      exp_n  = ok_rdy ? ready_at : int'(TIMEOUT);
      @(posedge clk); #1;
      n = 0;
      while (ctr_valid === 1'b1 && n < int'(TIMEOUT) + 4) begin
         chk("issue_grant", grant, exp_g);
         chk("issue_wstrb", ctr_wstrb, exp_s);
         chk("issue_wdata", ctr_wdata, exp_d);
         ctr_ready = (n + 1 == ready_at);
         ctr_rdata = rd;
         @(posedge clk); #1;
         ctr_ready = 1'b0;
         ctr_rdata = $urandom;
         n++;
      end
      chk("issue_len", n, exp_n);
      chk("resp_wb_ack", wb_ack, !own);
      chk("resp_la_ack", la_ack, own);
      chk("resp_wb_err", wb_err, !own && !ok_rdy);
      chk("resp_wb_rdata", wb_rdata, (!own && ok_rdy) ? rd : 32'h0);
      chk("resp_grant", grant, exp_g);
      chk("resp_busy", busy, 1);
      if (own) la_req = 1'b0;
      else     wb_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_wb_ack", wb_ack, 0);
      chk("idle_la_ack", la_ack, 0);
      chk("idle_busy", busy, 0);
      chk("idle_grant", grant, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < 4 && (wb_valid || la_req); i++) begin
         serve(2, $urandom);
      end
   endtask

   initial begin
      #2 reset_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;
      chk_all_zero("post_reset");

      // WB read, ready on third ISSUE cycle.
      raise_wb(1'b0, 4'hF, 32'h0);
      serve(3, 32'h0000_002A);

      // WB write with partial byte select.
      raise_wb(1'b1, 4'b0101, 32'hAABB_CCDD);
      serve(2, 32'h1111_0000);

      // LA load, ready on first cycle.
      raise_la(32'h1234_5678);
      serve(1, 32'hDEAD_0001);

      // Simultaneous requests, four transactions.
      for (int i = 0; i < 4; i++) begin
         if (!wb_valid) raise_wb(1'b1, 4'(i + 1), 32'h5000_0000 + i);
         if (!la_req)   raise_la(32'h6000_0000 + i);
         serve(1 + i, 32'h7000_0000 + i);
      end
      drain();

      // Timeout, then ready on the final allowed cycle.
      raise_wb(1'b0, 4'hF, 32'h0);
      serve(0, 32'hBAD0_BAD0);
      raise_wb(1'b0, 4'hF, 32'h0);
      serve(TIMEOUT, 32'h0000_BEEF);
      raise_la(32'hCAFE_F00D);
      serve(0, 32'h0);

      // Reset during ISSUE aborts without an ack.
      raise_wb(1'b1, 4'hF, 32'h1357_9BDF);
      @(posedge clk); #1;
      chk("pre_abort_valid", ctr_valid, 1);
      #2 reset_n = 1'b0;
      #1 chk_all_zero("abort");
      wb_valid = 1'b0;
      m_last   = 1'b1;
      @(posedge clk);
      #3 reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("abort_no_wb_ack", wb_ack, 0);
         chk("abort_no_la_ack", la_ack, 0);
      end
      raise_wb(1'b1, 4'h3, 32'h2468_ACE0);
      raise_la(32'h0F0F_0F0F);
      serve(2, 32'h0);
      drain();

      // Random traffic.
      for (int t = 0; t < 40; t++) begin
         if (!wb_valid && $urandom_range(1) == 1)
            raise_wb(1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
         if (!la_req && $urandom_range(1) == 1)
            raise_la($urandom);
         if (!wb_valid && !la_req)
            raise_wb(1'($urandom_range(1)), 4'($urandom_range(15)), $urandom);
         serve($urandom_range(0, TIMEOUT + 1), $urandom);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
